fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_INSTR, 32'h00000013, value of instr_d after reset (NOP).
REQ-002 Port: clk  in  1  clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: pc  in  32  current value from the PC register.
REQ-005 Port: pc_next  out  32  next-PC value driven into the PC register.
REQ-006 Port: stall_f  out  1  PC-register hold; 1 = PC keeps its value.
REQ-007 Port: stall_d  in  1  decode-stage hold from hazard unit.
REQ-008 Port: redirect_valid  in  1  branch/jump taken this cycle.
REQ-009 Port: redirect_pc  in  32  target address for redirect.
REQ-010 Port: imem_req  out  1  instruction memory request.
REQ-011 Port: imem_addr  out  32  request address.
REQ-012 Port: imem_ack  in  1  one-cycle pulse; imem_rdata valid in that cycle.
REQ-013 Port: imem_rdata  in  32  fetched instruction.
REQ-014 Port: instr_d, pc_d  out  32 each  fetch/decode pipeline register contents.
REQ-015 Port: valid_d  out  1  instr_d/pc_d hold a live instruction.

Function
REQ-016 pc_next SHALL be redirect_pc when redirect_valid=1, else pc+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-017 FSM SHALL have states FETCH, HOLD and DRAIN.
REQ-018 Memory protocol: once asserted, imem_req SHALL stay high with imem_addr stable until the imem_ack cycle; an ack in the same cycle as req assertion is legal.
REQ-019 FETCH: imem_req=1, imem_addr=pc.
REQ-020 FETCH, ack, no redirect, stall_d=0: instr_d<=imem_rdata, pc_d<=pc, valid_d<=1, stall_f=0; stay FETCH; zero-wait memory sustains 1 instr/cycle.
REQ-021 FETCH, ack, no redirect, stall_d=1: capture imem_rdata/pc into hold buffer, stall_f=1, decode registers unchanged, go HOLD.
REQ-022 FETCH, no ack, no redirect: stall_f=1; valid_d<=0 if stall_d=0, else decode registers unchanged.
REQ-023 HOLD: imem_req=0, stall_f=1 while stall_d=1; when stall_d=0, transfer buffer into instr_d/pc_d, valid_d<=1, stall_f=0, go FETCH.
REQ-024 DRAIN: imem_req=1, imem_addr=latched address of the abandoned request; on ack, discard data and go FETCH; decode registers get valid_d<=0.
REQ-025 Redirect priority: redirect_valid=1 in any state SHALL force stall_f=0 and valid_d<=0, overriding stall_d.
REQ-026 Redirect in FETCH without ack: latch imem_addr, go DRAIN.
REQ-027 Redirect in FETCH with ack, or in HOLD: discard fetched/buffered instruction, go FETCH.
REQ-028 Redirect in DRAIN: stay DRAIN, keep the original latched address.
REQ-029 Outside the cases above, stall_f SHALL be 1 and the decode registers unchanged.

Reset
REQ-030 While rst=1: state=FETCH, valid_d=0, instr_d=RESET_INSTR, pc_d=0, hold buffer and latched address 0, imem_req=0.
REQ-031 rst asserted mid-request SHALL abandon that request without a drain; a late ack after reset release SHALL be ignored unless imem_req=1 in that cycle.

Verification
REQ-032 Zero-wait memory, pc 0,4,8 -> instr_d follows rdata each cycle, pc_d=0,4,8, stall_f=0 every cycle.
REQ-033 Ack 3 cycles after req at pc=0x10 -> stall_f=1 for 3 cycles, valid_d=0 bubbles, then pc_d=0x10, valid_d=1.
REQ-034 stall_d=1 for 2 cycles at ack of pc=0x20 -> HOLD, decode regs unchanged; stall_d=0 -> pc_d=0x20 delivered, pc_next=0x24.
REQ-035 Redirect to 0x100 while req at 0x40 is pending -> pc_next=0x100, stall_f=0, imem_addr stays 0x40 until ack, data dropped, next req at 0x100, valid_d=0 throughout.
REQ-036 pc=0xFFFFFFFC with ack and stall_d=0 -> pc_next=0x00000000.
REQ-037 rst pulse while in HOLD -> valid_d=0, instr_d=0x00000013, state FETCH, imem_req=1 at pc=0 after release.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: drives the instruction memory request, computes the
// next PC, and loads the fetch/decode pipeline register.  A one-entry hold
// buffer absorbs an instruction that returns while decode is stalled, and a
// drain state retires a request that was abandoned by a redirect.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FETCH | request outstanding at pc; deliver on ack
//   HOLD  | fetched instruction parked in hold buffer, waiting for decode
//   DRAIN | abandoned request still in flight at latched address; drop data
module fetch_ctrl #(
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        stall_f,
    input  logic        stall_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [31:0] buf_instr_q, buf_instr_n;
    logic [31:0] buf_pc_q, buf_pc_n;
    logic [31:0] drain_addr_q, drain_addr_n;
    logic [31:0] instr_n;
    logic [31:0] pc_d_n;
    logic        valid_n;
    logic        ack_ok;

    // Memory-facing outputs; the request drops during reset and while parked in HOLD.
    always_comb begin
        imem_req  = !rst && (state_q != HOLD);
        imem_addr = (state_q == DRAIN) ? drain_addr_q : pc;
        ack_ok    = imem_ack && imem_req;
        pc_next   = redirect_valid ? redirect_pc : (pc + 32'd4);
    end

    // Next-state and decode-register update; redirect overrides everything at the end.
    always_comb begin
        state_n      = state_q;
        stall_f      = 1'b1;
        buf_instr_n  = buf_instr_q;
        buf_pc_n     = buf_pc_q;
        drain_addr_n = drain_addr_q;
        instr_n      = instr_d;
        pc_d_n       = pc_d;
        valid_n      = valid_d;

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    if (!ack_ok) begin
                        drain_addr_n = pc;
                        state_n      = DRAIN;
                    end
                end else if (ack_ok) begin
                    if (!stall_d) begin
                        stall_f = 1'b0;
                        instr_n = imem_rdata;
                        pc_d_n  = pc;
                        valid_n = 1'b1;
                    end else begin
                        buf_instr_n = imem_rdata;
                        buf_pc_n    = pc;
                        state_n     = HOLD;
                    end
                end else if (!stall_d) begin
                    valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_n = FETCH;
                end else if (!stall_d) begin
                    stall_f = 1'b0;
                    instr_n = buf_instr_q;
                    pc_d_n  = buf_pc_q;
                    valid_n = 1'b1;
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                // Data of the abandoned request is dropped; a redirect here keeps
                // the original address, and the ack still retires the request.
                valid_n = 1'b0;
                if (ack_ok) begin
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        if (redirect_valid) begin
            stall_f = 1'b0;
            valid_n = 1'b0;
            instr_n = instr_d;
            pc_d_n  = pc_d;
        end
    end

    // State, hold buffer, drain address and decode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            buf_instr_q  <= 32'd0;
            buf_pc_q     <= 32'd0;
            drain_addr_q <= 32'd0;
            instr_d      <= RESET_INSTR;
            pc_d         <= 32'd0;
            valid_d      <= 1'b0;
        end else begin
            state_q      <= state_n;
            buf_instr_q  <= buf_instr_n;
            buf_pc_q     <= buf_pc_n;
            drain_addr_q <= drain_addr_n;
            instr_d      <= instr_n;
            pc_d         <= pc_d_n;
            valid_d      <= valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a PC register and a variable-latency memory
// surround the DUT; a transaction model predicts the stream of instructions
// that decode consumes, and a monitor pops and compares each consumption.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'd0;
    logic [31:0] pc_next;
    logic        stall_f;
    logic        stall_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;

    fetch_ctrl #(.RESET_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next), .stall_f(stall_f),
        .stall_d(stall_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_t;

    fetch_t      live_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_consumed = 0;

    // transaction-level model of where fetched instructions currently sit
    bit          dec_live, buf_live, abandoned;
    logic [31:0] ab_addr;
    // memory model
    bit          mbusy;
    int          mcnt, mlat;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F1E2D3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        live_q.delete();
        dec_live  = 0;
        buf_live  = 0;
        abandoned = 0;
        ab_addr   = 32'd0;
        mbusy     = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk); #1;
        rst = 1'b1;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid_d", {31'd0, valid_d}, 32'd0);
        chk("rst_instr_d", instr_d, NOP);
        chk("rst_pc_d", pc_d, 32'd0);
        model_reset();
        pc = 32'd0;
        repeat (cycles) begin
            @(negedge clk); #1;
            imem_ack = $urandom_range(0, 1) == 1;  // late acks from the abandoned request
        end
        @(negedge clk); #1;
        imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_imem_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_imem_addr", imem_addr, 32'd0);
    endtask

    // Monitor: decode consumes the presented instruction when it is not stalled
    // and not squashed; compare against the oldest live fetch.
    initial begin
        fetch_t e;
        forever begin
            @(negedge clk); #3;
            if (!rst && valid_d && !stall_d && !redirect_valid) begin
                if (live_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL consume_unexpected: got pc_d %h, no live fetch expected", pc_d);
                end else begin
                    e = live_q.pop_front();
                    chk("consume_pc_d", pc_d, e.addr);
                    chk("consume_instr_d", instr_d, e.instr);
                    n_consumed++;
                end
            end
        end
    end

    // Driver, memory, PC register and reference model.
    initial begin
        bit          ack_v, exp_req, exp_stall_f, did_hold_rst;
        logic [31:0] exp_addr, exp_pc_next, pc_new;
        model_reset();
        did_hold_rst = 0;
        do_reset(2);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 1500 || (cyc > 2500 && buf_live && !did_hold_rst)) begin
                if (cyc != 1500) begin
                    did_hold_rst = 1;
                    chk("hold_before_rst_req", {31'd0, imem_req}, 32'd0);
                end
                do_reset(1 + (cyc % 2));
                continue;
            end
            @(negedge clk); #1;
            // memory: variable latency, stray acks while no request is up
            if (imem_req) begin
                if (!mbusy) begin
                    mbusy = 1; mcnt = 0;
                    mlat = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                end
                ack_v = (mcnt == mlat);
                if (ack_v) mbusy = 0; else mcnt++;
            end else begin
                ack_v = ($urandom_range(0, 7) == 0);
            end
            imem_ack   = ack_v;
            imem_rdata = ack_v ? mem_data(imem_addr) : $urandom;
            stall_d    = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0) || (cyc == 700);
            if (cyc == 700 || $urandom_range(0, 5) == 0)
                redirect_pc = 32'hFFFFFFF8 | {29'd0, $urandom_range(0, 1) == 1, 2'b00};
            else
                redirect_pc = $urandom & 32'h0000FFFC;
            #1;
            exp_req  = !buf_live;
            exp_addr = abandoned ? ab_addr : pc;
            exp_pc_next = redirect_valid ? redirect_pc : pc + 32'd4;
            if (redirect_valid)      exp_stall_f = 0;
            else if (buf_live)       exp_stall_f = stall_d;
            else if (abandoned)      exp_stall_f = 1;
            else                     exp_stall_f = !(ack_v && !stall_d);
            chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            if (exp_req) chk("imem_addr", imem_addr, exp_addr);
            chk("pc_next", pc_next, exp_pc_next);
            chk("stall_f", {31'd0, stall_f}, {31'd0, exp_stall_f});
            chk("valid_d", {31'd0, valid_d}, {31'd0, dec_live});
            // advance the model across the coming edge
            if (redirect_valid) begin
                if (!buf_live && !abandoned && !ack_v) begin
                    abandoned = 1; ab_addr = pc;
                end else if (abandoned && ack_v) begin
                    abandoned = 0;
                end
                live_q.delete();
                dec_live = 0; buf_live = 0;
            end else if (buf_live) begin
                if (!stall_d) begin dec_live = 1; buf_live = 0; end
            end else if (abandoned) begin
                if (ack_v) abandoned = 0;
                dec_live = 0;
            end else if (ack_v) begin
                live_q.push_back('{addr: pc, instr: mem_data(pc)});
                if (!stall_d) dec_live = 1; else buf_live = 1;
            end else if (!stall_d) begin
                dec_live = 0;
            end
            pc_new = exp_stall_f ? pc : exp_pc_next;
            @(posedge clk); #1;
            pc = pc_new;
        end
        repeat (2) @(negedge clk);
        chk("enough_consumed", {31'd0, n_consumed > 300}, 32'd1);
        chk("hold_reset_seen", {31'd0, did_hold_rst}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d compares", n_cmp);
        $fatal(1);
    end

endmodule
